// File: rtl/circuito_pkg.sv
// Shared constants and types for the dual digit adder.
package circuito_pkg;

   localparam logic COD_BIN = 1'b0;
   localparam logic COD_BCD = 1'b1;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   typedef logic [3:0] digit_t;

endpackage

// File: rtl/circuito_add4_code.sv
// Combinational 4-bit adder with binary or BCD (decimal-adjusted) result.
module add4_code
   import circuito_pkg::*;
(
   input  digit_t a,
   input  digit_t b,
   input  logic   cod,
   output digit_t digit,
   output logic   carry
);

   logic [4:0] s;

   assign s = {1'b0, a} + {1'b0, b};

   always_comb begin
      digit = s[3:0];
      carry = 1'b0;
      unique case (cod)
         COD_BIN: begin
            carry = s[4];
         end
         COD_BCD: begin
            // Low nibble of s+6 equals (s+6)[3:0] for the full 0..30 range.
            if (s > {1'b0, BCD_MAX}) begin
               digit = s[3:0] + BCD_ADJ;
               carry = 1'b1;
            end
         end
         default: begin
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/circuito.sv
// Dual registered digit adder: ch0 = A+X, ch1 = A+Y, binary or BCD.
// Optional CIRCUITO_BCD_CHECK_EN adds a registered ERR for non-BCD operands.
module circuito
   import circuito_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   HAB,
   input  logic   COD,
   input  digit_t A,
   input  digit_t X,
   input  digit_t Y,
   output digit_t B,
   output digit_t C,
   output logic   Cout0,
   output logic   Cout1
`ifdef CIRCUITO_BCD_CHECK_EN
   ,
   output logic   ERR
`endif
);

   digit_t d0;
   digit_t d1;
   logic   c0;
   logic   c1;

   add4_code u_ch0 (
      .a     (A),
      .b     (X),
      .cod   (COD),
      .digit (d0),
      .carry (c0)
   );

   add4_code u_ch1 (
      .a     (A),
      .b     (Y),
      .cod   (COD),
      .digit (d1),
      .carry (c1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         B     <= '0;
         C     <= '0;
         Cout0 <= 1'b0;
         Cout1 <= 1'b0;
      end else if (HAB) begin
         B     <= d0;
         C     <= d1;
         Cout0 <= c0;
         Cout1 <= c1;
      end else begin
         B     <= '0;
         C     <= '0;
         Cout0 <= 1'b0;
         Cout1 <= 1'b0;
      end
   end

`ifdef CIRCUITO_BCD_CHECK_EN
   logic bad;

   assign bad = (A > BCD_MAX) || (X > BCD_MAX) || (Y > BCD_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         ERR <= 1'b0;
      end else begin
         ERR <= HAB && (COD == COD_BCD) && bad;
      end
   end
`endif

endmodule

// File: tb/tb_circuito.sv
// Scoreboard bench for circuito: expected results queued at drive, checked after the edge.
module tb_circuito;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       HAB = 1'b0;
   logic       COD = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] X = '0;
   logic [3:0] Y = '0;
   logic [3:0] B;
   logic [3:0] C;
   logic       Cout0;
   logic       Cout1;
   logic       ERR;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0] b;
      logic [3:0] c;
      logic       c0;
      logic       c1;
      logic       err;
   } exp_t;

   exp_t sb[$];

   circuito dut (
      .clk   (clk),
      .rst   (rst),
      .HAB   (HAB),
      .COD   (COD),
      .A     (A),
      .X     (X),
      .Y     (Y),
      .B     (B),
      .C     (C),
      .Cout0 (Cout0),
      .Cout1 (Cout1)
`ifdef CIRCUITO_BCD_CHECK_EN
      ,
      .ERR   (ERR)
`endif
   );

`ifndef CIRCUITO_BCD_CHECK_EN
   assign ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic void ch(input int a, input int o, input logic cod,
                              output logic [3:0] d, output logic cy);
      int sum;
      sum = a + o;
      if (cod && sum > 9) begin
         d  = 4'((sum - 10) % 16);
         cy = 1'b1;
      end else begin
         d  = 4'(sum % 16);
         cy = (sum > 15);
      end
   endfunction

   function automatic exp_t model(input logic r, input logic hab, input logic cod,
                                  input logic [3:0] a, input logic [3:0] x,
                                  input logic [3:0] y);
      exp_t e;
      e = '0;
      if (!r && hab) begin
         ch(int'(a), int'(x), cod, e.b, e.c0);
         ch(int'(a), int'(y), cod, e.c, e.c1);
         e.err = cod && (a > 9 || x > 9 || y > 9);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      n_assert++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_queue: got %0d entries expected >0", tag, sb.size());
         return;
      end
      e = sb.pop_front();
      chk({tag, "_B"}, B, e.b);
      chk({tag, "_C"}, C, e.c);
      chk({tag, "_Cout0"}, {3'b0, Cout0}, {3'b0, e.c0});
      chk({tag, "_Cout1"}, {3'b0, Cout1}, {3'b0, e.c1});
`ifdef CIRCUITO_BCD_CHECK_EN
      chk({tag, "_ERR"}, {3'b0, ERR}, {3'b0, e.err});
`endif
   endtask

   task automatic step(input string tag, input logic r, input logic hab,
                       input logic cod, input logic [3:0] a, input logic [3:0] x,
                       input logic [3:0] y, input exp_t e);
      @(negedge clk);
      rst = r;
      HAB = hab;
      COD = cod;
      A   = a;
      X   = x;
      Y   = y;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   task automatic mstep(input string tag, input logic r, input logic hab,
                        input logic cod, input logic [3:0] a, input logic [3:0] x,
                        input logic [3:0] y);
      step(tag, r, hab, cod, a, x, y, model(r, hab, cod, a, x, y));
   endtask

   initial begin
      exp_t z;
      z = '0;

      step("rst0", 1'b1, 1'b1, 1'b1, 4'hC, 4'hF, 4'h9, z);
      step("rst1", 1'b1, 1'b1, 1'b0, 4'h9, 4'h9, 4'h9, z);

      for (int a = 0; a < 10; a++) begin
         step("hab0_bin", 1'b0, 1'b0, 1'b0, 4'(a), 4'd5, 4'd1, z);
         step("hab0_bcd", 1'b0, 1'b0, 1'b1, 4'(a), 4'd5, 4'd1, z);
      end

      step("bin_a9", 1'b0, 1'b1, 1'b0, 4'd9, 4'd5, 4'd1,
           '{b: 4'hE, c: 4'hA, c0: 1'b0, c1: 1'b0, err: 1'b0});
      step("bin_a0", 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 4'd1,
           '{b: 4'h5, c: 4'h1, c0: 1'b0, c1: 1'b0, err: 1'b0});
      step("bcd_a9", 1'b0, 1'b1, 1'b1, 4'd9, 4'd5, 4'd1,
           '{b: 4'h4, c: 4'h0, c0: 1'b1, c1: 1'b1, err: 1'b0});
      step("bcd_a4", 1'b0, 1'b1, 1'b1, 4'd4, 4'd5, 4'd1,
           '{b: 4'h9, c: 4'h5, c0: 1'b0, c1: 1'b0, err: 1'b0});
      step("bcd_a5", 1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 4'd1,
           '{b: 4'h0, c: 4'h6, c0: 1'b1, c1: 1'b0, err: 1'b0});
      step("bin_99", 1'b0, 1'b1, 1'b0, 4'd9, 4'd9, 4'd1,
           '{b: 4'h2, c: 4'hA, c0: 1'b1, c1: 1'b0, err: 1'b0});
      step("bcd_99", 1'b0, 1'b1, 1'b1, 4'd9, 4'd9, 4'd1,
           '{b: 4'h8, c: 4'h0, c0: 1'b1, c1: 1'b1, err: 1'b0});
      step("bin_max", 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 4'h1,
           '{b: 4'hE, c: 4'h0, c0: 1'b1, c1: 1'b1, err: 1'b0});
      step("bcd_max", 1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 4'h0,
           '{b: 4'h4, c: 4'h5, c0: 1'b1, c1: 1'b1, err: 1'b1});

      step("err_bcd", 1'b0, 1'b1, 1'b1, 4'hC, 4'd5, 4'd1,
           '{b: 4'h7, c: 4'h3, c0: 1'b1, c1: 1'b1, err: 1'b1});
      step("err_bin", 1'b0, 1'b1, 1'b0, 4'hC, 4'd5, 4'd1,
           '{b: 4'h1, c: 4'hD, c0: 1'b1, c1: 1'b0, err: 1'b0});
      step("err_set", 1'b0, 1'b1, 1'b1, 4'hC, 4'd5, 4'd1,
           '{b: 4'h7, c: 4'h3, c0: 1'b1, c1: 1'b1, err: 1'b1});
      step("mid_rst", 1'b1, 1'b1, 1'b1, 4'hC, 4'd5, 4'd1, z);
      step("after_rst", 1'b0, 1'b1, 1'b1, 4'd3, 4'd4, 4'd8,
           '{b: 4'h7, c: 4'h1, c0: 1'b0, c1: 1'b1, err: 1'b0});

      for (int i = 0; i < 60; i++) begin
         mstep("rand", 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) != 0),
               1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end

      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_drain: got %0d entries expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
